// File: rtl/dsp48a1_pkg.sv
// rtl/dsp48a1_pkg.sv - shared constants, mux codes and post-adder helper for the dsp48a1 slice
// Purpose: OPMODE bit positions, X/Z mux select encodings, CARRYINSEL/B_INPUT/RSTTYPE
//          string constants and the 49-bit post-adder arithmetic.
// Ports:   none (package)
package dsp48a1_pkg;

    // OPMODE bit positions
    localparam int OPM_X_LO     = 0;
    localparam int OPM_Z_LO     = 2;
    localparam int OPM_PRE_SEL  = 4;
    localparam int OPM_CIN      = 5;
    localparam int OPM_PRE_SUB  = 6;
    localparam int OPM_POST_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } zsel_e;

    localparam string CARRYINSEL_OPMODE5 = "OPMODE5";
    localparam string CARRYINSEL_CARRYIN = "CARRYIN";
    localparam string B_INPUT_DIRECT     = "DIRECT";
    localparam string B_INPUT_CASCADE    = "CASCADE";
    localparam string RSTTYPE_SYNC       = "SYNC";

    // Returns {carry_or_borrow, sum}. For subtraction the carry-in joins X before
    // negation, so a negative result shows up as bit 48 set (borrow).
    function automatic logic [48:0] post_add(
        input logic        sub,
        input logic [47:0] z,
        input logic [47:0] x,
        input logic        cin
    );
        logic [48:0] x_cin;
        x_cin = {1'b0, x} + {48'd0, cin};
        if (sub)
            post_add = {1'b0, z} - x_cin;
        else
            post_add = {1'b0, z} + x_cin;
    endfunction

endpackage

// File: rtl/dsp48a1_if.sv
// rtl/dsp48a1_if.sv - operand/result bundle of the dsp48a1 slice
// Purpose: groups the data operands, OPMODE and results of the slice.
// Ports:   master drives i_* operands and reads o_* results; slave is the slice side.
interface dsp48a1_if;
    import dsp48a1_pkg::*;

    logic [17:0] i_a;
    logic [17:0] i_b;
    logic [17:0] i_bcin;
    logic [17:0] i_d;
    logic [47:0] i_c;
    logic [47:0] i_pcin;
    logic        i_carryin;
    logic [7:0]  i_opmode;
    logic [35:0] o_m;
    logic [47:0] o_p;
    logic [47:0] o_pcout;
    logic [17:0] o_bcout;
    logic        o_carryout;
    logic        o_carryoutf;

    modport master (
        output i_a, i_b, i_bcin, i_d, i_c, i_pcin, i_carryin, i_opmode,
        input  o_m, o_p, o_pcout, o_bcout, o_carryout, o_carryoutf
    );

    modport slave (
        input  i_a, i_b, i_bcin, i_d, i_c, i_pcin, i_carryin, i_opmode,
        output o_m, o_p, o_pcout, o_bcout, o_carryout, o_carryoutf
    );
endinterface

// File: rtl/dsp_pipe_reg.sv
// rtl/dsp_pipe_reg.sv - optional pipeline stage with clock enable, sync reset and bypass
// Purpose: EN=1 gives a rising-edge register (reset beats CE, CE low holds);
//          EN=0 gives a combinational pass-through.
// Ports:   i_clk clock, i_rst sync active-high reset, i_ce clock enable,
//          i_d stage input, o_q stage output.
module dsp_pipe_reg #(
    parameter int WIDTH = 18,
    parameter int EN    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    generate
        if (EN != 0) begin : g_reg
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge i_clk) begin
                if (i_rst)
                    r_q <= '0;
                else if (i_ce)
                    r_q <= i_d;
            end
            assign o_q = r_q;
        end else begin : g_bypass
            logic w_unused_ctrl;
            assign w_unused_ctrl = ^{i_clk, i_rst, i_ce};
            assign o_q = i_d;
        end
    endgenerate
endmodule

// File: rtl/dsp48a1.sv
// rtl/dsp48a1.sv - DSP slice: pre-adder, 18x18 multiplier, 48-bit post-adder
// Purpose: Spartan-6 style DSP slice with per-stage optional registers.
// Ports:   i_clk clock; i_rst* per-stage sync active-high resets; i_ce* per-stage
//          clock enables; bus carries A/B/BCIN/D/C/PCIN/CARRYIN/OPMODE in and
//          M/P/PCOUT/BCOUT/CARRYOUT/CARRYOUTF out.
module dsp48a1
    import dsp48a1_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT",
    parameter string RSTTYPE     = "SYNC"
) (
    input  logic i_clk,
    input  logic i_rsta,
    input  logic i_rstb,
    input  logic i_rstc,
    input  logic i_rstd,
    input  logic i_rstm,
    input  logic i_rstp,
    input  logic i_rstcarryin,
    input  logic i_rstopmode,
    input  logic i_cea,
    input  logic i_ceb,
    input  logic i_cec,
    input  logic i_ced,
    input  logic i_cem,
    input  logic i_cep,
    input  logic i_cecarryin,
    input  logic i_ceopmode,
    dsp48a1_if.slave bus
);
    // Only synchronous resets exist in this slice.
    localparam bit RST_IS_SYNC = (RSTTYPE == RSTTYPE_SYNC);

    logic [17:0] w_a0, w_a1, w_b_src, w_b0, w_b1, w_d, w_pre, w_b1_in;
    logic [47:0] w_c, w_x, w_z, w_p;
    logic [7:0]  w_opm;
    logic [35:0] w_mult, w_m;
    logic        w_cin_src, w_cyi, w_cyo;
    logic [48:0] w_post;
    logic        w_unused_inputs;

    assign w_unused_inputs = ^{bus.i_bcin, bus.i_carryin, RST_IS_SYNC};

    // B source selection
    generate
        if (B_INPUT == B_INPUT_DIRECT) begin : g_b_direct
            assign w_b_src = bus.i_b;
        end else if (B_INPUT == B_INPUT_CASCADE) begin : g_b_cascade
            assign w_b_src = bus.i_bcin;
        end else begin : g_b_zero
            assign w_b_src = '0;
        end
    endgenerate

    // Carry-in source selection (before the CYI stage)
    generate
        if (CARRYINSEL == CARRYINSEL_OPMODE5) begin : g_cin_opm
            assign w_cin_src = w_opm[OPM_CIN];
        end else if (CARRYINSEL == CARRYINSEL_CARRYIN) begin : g_cin_port
            assign w_cin_src = bus.i_carryin;
        end else begin : g_cin_zero
            assign w_cin_src = 1'b0;
        end
    endgenerate

    dsp_pipe_reg #(.WIDTH(8), .EN(OPMODEREG)) u_opm (
        .i_clk(i_clk), .i_rst(i_rstopmode), .i_ce(i_ceopmode), .i_d(bus.i_opmode), .o_q(w_opm)
    );

    dsp_pipe_reg #(.WIDTH(18), .EN(A0REG)) u_a0 (
        .i_clk(i_clk), .i_rst(i_rsta), .i_ce(i_cea), .i_d(bus.i_a), .o_q(w_a0)
    );

    dsp_pipe_reg #(.WIDTH(18), .EN(A1REG)) u_a1 (
        .i_clk(i_clk), .i_rst(i_rsta), .i_ce(i_cea), .i_d(w_a0), .o_q(w_a1)
    );

    dsp_pipe_reg #(.WIDTH(18), .EN(B0REG)) u_b0 (
        .i_clk(i_clk), .i_rst(i_rstb), .i_ce(i_ceb), .i_d(w_b_src), .o_q(w_b0)
    );

    dsp_pipe_reg #(.WIDTH(18), .EN(DREG)) u_d (
        .i_clk(i_clk), .i_rst(i_rstd), .i_ce(i_ced), .i_d(bus.i_d), .o_q(w_d)
    );

    dsp_pipe_reg #(.WIDTH(48), .EN(CREG)) u_c (
        .i_clk(i_clk), .i_rst(i_rstc), .i_ce(i_cec), .i_d(bus.i_c), .o_q(w_c)
    );

    // Pre-adder wraps modulo 2^18; its result only replaces B when opm[4] is set.
    assign w_pre   = w_opm[OPM_PRE_SUB] ? (w_d - w_b0) : (w_d + w_b0);
    assign w_b1_in = w_opm[OPM_PRE_SEL] ? w_pre : w_b0;

    dsp_pipe_reg #(.WIDTH(18), .EN(B1REG)) u_b1 (
        .i_clk(i_clk), .i_rst(i_rstb), .i_ce(i_ceb), .i_d(w_b1_in), .o_q(w_b1)
    );

    assign w_mult = {18'd0, w_a1} * {18'd0, w_b1};

    dsp_pipe_reg #(.WIDTH(36), .EN(MREG)) u_m (
        .i_clk(i_clk), .i_rst(i_rstm), .i_ce(i_cem), .i_d(w_mult), .o_q(w_m)
    );

    dsp_pipe_reg #(.WIDTH(1), .EN(CARRYINREG)) u_cyi (
        .i_clk(i_clk), .i_rst(i_rstcarryin), .i_ce(i_cecarryin), .i_d(w_cin_src), .o_q(w_cyi)
    );

    // X/Z operand muxes; P feedback uses the P stage output, so a disabled P
    // register feeds back its held value.
    always_comb begin
        w_x = '0;
        case (xsel_e'(w_opm[OPM_X_LO +: 2]))
            X_ZERO:  w_x = '0;
            X_M:     w_x = {12'd0, w_m};
            X_P:     w_x = w_p;
            X_DAB:   w_x = {w_d[11:0], w_a1, w_b1};
            default: w_x = '0;
        endcase
    end

    always_comb begin
        w_z = '0;
        case (zsel_e'(w_opm[OPM_Z_LO +: 2]))
            Z_ZERO:  w_z = '0;
            Z_PCIN:  w_z = bus.i_pcin;
            Z_P:     w_z = w_p;
            Z_C:     w_z = w_c;
            default: w_z = '0;
        endcase
    end

    assign w_post = post_add(w_opm[OPM_POST_SUB], w_z, w_x, w_cyi);

    dsp_pipe_reg #(.WIDTH(48), .EN(PREG)) u_p (
        .i_clk(i_clk), .i_rst(i_rstp), .i_ce(i_cep), .i_d(w_post[47:0]), .o_q(w_p)
    );

    // Carry-out shares the carry-in stage controls, not the P stage controls.
    dsp_pipe_reg #(.WIDTH(1), .EN(CARRYOUTREG)) u_cyo (
        .i_clk(i_clk), .i_rst(i_rstcarryin), .i_ce(i_cecarryin), .i_d(w_post[48]), .o_q(w_cyo)
    );

    assign bus.o_m         = w_m;
    assign bus.o_p         = w_p;
    assign bus.o_pcout     = w_p;
    assign bus.o_bcout     = w_b1;
    assign bus.o_carryout  = w_cyo;
    assign bus.o_carryoutf = w_cyo;

endmodule

// File: tb/tb_dsp48a1.sv
// tb/tb_dsp48a1.sv - directed self-checking bench for dsp48a1
module tb_dsp48a1;
    import dsp48a1_pkg::*;

    logic clk = 1'b0;
    logic rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode;
    logic cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode;
    int   n_checks = 0;
    int   n_fail   = 0;

    dsp48a1_if bus ();

    dsp48a1 dut (
        .i_clk(clk),
        .i_rsta(rsta), .i_rstb(rstb), .i_rstc(rstc), .i_rstd(rstd),
        .i_rstm(rstm), .i_rstp(rstp), .i_rstcarryin(rstcarryin), .i_rstopmode(rstopmode),
        .i_cea(cea), .i_ceb(ceb), .i_cec(cec), .i_ced(ced),
        .i_cem(cem), .i_cep(cep), .i_cecarryin(cecarryin), .i_ceopmode(ceopmode),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rst(input logic v);
        rsta = v; rstb = v; rstc = v; rstd = v;
        rstm = v; rstp = v; rstcarryin = v; rstopmode = v;
    endtask

    task automatic set_ce(input logic v);
        cea = v; ceb = v; cec = v; ced = v;
        cem = v; cep = v; cecarryin = v; ceopmode = v;
    endtask

    task automatic test_reset;
        set_rst(1'b1);
        cea = 1'($urandom); ceb = 1'($urandom); cec = 1'($urandom); ced = 1'($urandom);
        cem = 1'($urandom); cep = 1'($urandom); cecarryin = 1'($urandom); ceopmode = 1'($urandom);
        bus.i_a = 18'($urandom); bus.i_b = 18'($urandom); bus.i_bcin = 18'($urandom);
        bus.i_d = 18'($urandom); bus.i_c = {16'($urandom), 32'($urandom)};
        bus.i_pcin = {16'($urandom), 32'($urandom)};
        bus.i_carryin = 1'($urandom); bus.i_opmode = 8'($urandom);
        tick(1);
        n_checks++; if (bus.o_p !== 48'd0) begin n_fail++; $display("FAIL reset_p got %h want 0", bus.o_p); end
        n_checks++; if (bus.o_m !== 36'd0) begin n_fail++; $display("FAIL reset_m got %h want 0", bus.o_m); end
        n_checks++; if (bus.o_bcout !== 18'd0) begin n_fail++; $display("FAIL reset_bcout got %h want 0", bus.o_bcout); end
        n_checks++; if (bus.o_pcout !== 48'd0) begin n_fail++; $display("FAIL reset_pcout got %h want 0", bus.o_pcout); end
        n_checks++; if (bus.o_carryout !== 1'b0) begin n_fail++; $display("FAIL reset_carryout got %b want 0", bus.o_carryout); end
        n_checks++; if (bus.o_carryoutf !== 1'b0) begin n_fail++; $display("FAIL reset_carryoutf got %b want 0", bus.o_carryoutf); end
    endtask

    // D-B pre-subtract, M into post-subtract from C: 350 - 20*(25-10) = 50
    task automatic test_presub_postsub;
        set_rst(1'b0);
        set_ce(1'b1);
        bus.i_opmode = 8'hDD; bus.i_a = 18'd20; bus.i_b = 18'd10; bus.i_d = 18'd25;
        bus.i_c = 48'd350; bus.i_pcin = 48'd0; bus.i_carryin = 1'b0; bus.i_bcin = 18'd0;
        tick(4);
        n_checks++; if (bus.o_bcout !== 18'h0F) begin n_fail++; $display("FAIL t2_bcout got %h want 0f", bus.o_bcout); end
        n_checks++; if (bus.o_m !== 36'h12C) begin n_fail++; $display("FAIL t2_m got %h want 12c", bus.o_m); end
        n_checks++; if (bus.o_p !== 48'h32) begin n_fail++; $display("FAIL t2_p got %h want 32", bus.o_p); end
        n_checks++; if (bus.o_pcout !== 48'h32) begin n_fail++; $display("FAIL t2_pcout got %h want 32", bus.o_pcout); end
        n_checks++; if (bus.o_carryout !== 1'b0) begin n_fail++; $display("FAIL t2_carryout got %b want 0", bus.o_carryout); end
    endtask

    // Pre-add only, X=Z=0 so P is zero: B1 = 25+10 = 35, M = 700
    task automatic test_preadd;
        bus.i_opmode = 8'h10;
        tick(3);
        n_checks++; if (bus.o_bcout !== 18'h23) begin n_fail++; $display("FAIL t3_bcout got %h want 23", bus.o_bcout); end
        n_checks++; if (bus.o_m !== 36'h2BC) begin n_fail++; $display("FAIL t3_m got %h want 2bc", bus.o_m); end
        n_checks++; if (bus.o_p !== 48'd0) begin n_fail++; $display("FAIL t3_p got %h want 0", bus.o_p); end
        n_checks++; if (bus.o_carryout !== 1'b0) begin n_fail++; $display("FAIL t3_carryout got %b want 0", bus.o_carryout); end
    endtask

    // B passes straight to B1; P = P + P stays at the held zero
    task automatic test_feedback;
        bus.i_opmode = 8'h0A;
        tick(3);
        n_checks++; if (bus.o_bcout !== 18'h0A) begin n_fail++; $display("FAIL t4_bcout got %h want 0a", bus.o_bcout); end
        n_checks++; if (bus.o_m !== 36'hC8) begin n_fail++; $display("FAIL t4_m got %h want c8", bus.o_m); end
        n_checks++; if (bus.o_p !== 48'd0) begin n_fail++; $display("FAIL t4_p got %h want 0", bus.o_p); end
        n_checks++; if (bus.o_carryout !== 1'b0) begin n_fail++; $display("FAIL t4_carryout got %b want 0", bus.o_carryout); end
    endtask

    // PCIN - ({D[11:0],A,B} + 1): 3000 - 0x019000140007 wraps, borrow set
    task automatic test_concat_borrow;
        bus.i_opmode = 8'hA7; bus.i_a = 18'd5; bus.i_b = 18'd6; bus.i_d = 18'd25;
        bus.i_pcin = 48'd3000;
        tick(3);
        n_checks++; if (bus.o_bcout !== 18'd6) begin n_fail++; $display("FAIL t5_bcout got %h want 6", bus.o_bcout); end
        n_checks++; if (bus.o_m !== 36'h1E) begin n_fail++; $display("FAIL t5_m got %h want 1e", bus.o_m); end
        n_checks++; if (bus.o_p !== 48'hFE6FFFEC0BB1) begin n_fail++; $display("FAIL t5_p got %h want fe6fffec0bb1", bus.o_p); end
        n_checks++; if (bus.o_pcout !== 48'hFE6FFFEC0BB1) begin n_fail++; $display("FAIL t5_pcout got %h want fe6fffec0bb1", bus.o_pcout); end
        n_checks++; if (bus.o_carryout !== 1'b1) begin n_fail++; $display("FAIL t5_carryout got %b want 1", bus.o_carryout); end
        n_checks++; if (bus.o_carryoutf !== 1'b1) begin n_fail++; $display("FAIL t5_carryoutf got %b want 1", bus.o_carryoutf); end
    endtask

    // P and carry stages disabled while upstream moves; then reset only P
    task automatic test_hold_and_rstp;
        cep = 1'b0; cecarryin = 1'b0;
        bus.i_a = 18'd7; bus.i_b = 18'd3; bus.i_pcin = 48'd12345;
        tick(3);
        n_checks++; if (bus.o_p !== 48'hFE6FFFEC0BB1) begin n_fail++; $display("FAIL t6_hold_p got %h want fe6fffec0bb1", bus.o_p); end
        n_checks++; if (bus.o_carryout !== 1'b1) begin n_fail++; $display("FAIL t6_hold_carryout got %b want 1", bus.o_carryout); end
        n_checks++; if (bus.o_m !== 36'h15) begin n_fail++; $display("FAIL t6_m got %h want 15", bus.o_m); end
        n_checks++; if (bus.o_bcout !== 18'd3) begin n_fail++; $display("FAIL t6_bcout got %h want 3", bus.o_bcout); end
        rstp = 1'b1;
        tick(1);
        rstp = 1'b0;
        n_checks++; if (bus.o_p !== 48'd0) begin n_fail++; $display("FAIL t6_rstp_p got %h want 0", bus.o_p); end
        n_checks++; if (bus.o_pcout !== 48'd0) begin n_fail++; $display("FAIL t6_rstp_pcout got %h want 0", bus.o_pcout); end
        n_checks++; if (bus.o_m !== 36'h15) begin n_fail++; $display("FAIL t6_rstp_m got %h want 15", bus.o_m); end
        n_checks++; if (bus.o_bcout !== 18'd3) begin n_fail++; $display("FAIL t6_rstp_bcout got %h want 3", bus.o_bcout); end
        n_checks++; if (bus.o_carryout !== 1'b1) begin n_fail++; $display("FAIL t6_rstp_carryout got %b want 1", bus.o_carryout); end
    endtask

    initial begin
        set_rst(1'b1);
        set_ce(1'b0);
        bus.i_a = '0; bus.i_b = '0; bus.i_bcin = '0; bus.i_d = '0;
        bus.i_c = '0; bus.i_pcin = '0; bus.i_carryin = 1'b0; bus.i_opmode = '0;
        #1;
        test_reset();
        test_presub_postsub();
        test_preadd();
        test_feedback();
        test_concat_borrow();
        test_hold_and_rstp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
